dmem_mmio: RTL and testbench

//  Data-side responder for the single-cycle mips core: replaces plain dmem on the

---
 rtl/dmem_mmio.sv | 72 +++++++
 tb/tb_dmem_mmio.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side responder for the single-cycle mips core (word RAM + MMIO page)
//   clk, reset (async, active-high)
//   memwrite, dataadr, writedata -> core write strobe, byte address, write data
//   readdata                     <- combinational read data for dataadr
//   gpio_out                     <- OUT_REG contents
//   tx_data, tx_valid, tx_ready  -> TX FIFO drain port (head byte, non-empty, consumer accept)
module dmem_mmio #(
  parameter int RAM_AW = 6,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [31:0] ram [2**RAM_AW];
  logic [7:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0] cycle, status, io_rd;
  logic [7:0] off;
  logic overflow, full, empty, ram_hit, io_hit, io_wr, push, pop, accept;
  assign ram_hit = dataadr[31:RAM_AW+2] == '0;
  assign io_hit = dataadr[31:8] == 24'hFFFFFF;
  assign off = dataadr[7:0];
  assign io_wr = memwrite & io_hit;
  assign full = count == CW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign tx_valid = !empty;
  assign tx_data = empty ? 8'h00 : fifo[rd_ptr];
  assign pop = tx_valid & tx_ready;
  assign push = io_wr & (off == 8'h04);
  // a push into a full FIFO still lands if the head leaves on the same edge
  assign accept = push & (!full | pop);
  assign status = {16'h0, 8'(count), 5'h0, overflow, empty, full};
  always_comb begin
    io_rd = off == 8'h00 ? gpio_out :
            off == 8'h08 ? status :
            off == 8'h0C ? cycle : 32'h0;
    readdata = ram_hit ? ram[dataadr[RAM_AW+1:2]] : io_hit ? io_rd : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (memwrite & ram_hit) ram[dataadr[RAM_AW+1:2]] <= writedata;
    if (accept) fifo[wr_ptr] <= writedata[7:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      cycle <= '0;
    end else begin
      if (io_wr & (off == 8'h00)) gpio_out <= writedata;
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(accept) - CW'(pop);
      if (push & full & !pop) overflow <= 1'b1;
      else if (io_wr & (off == 8'h08) & writedata[2]) overflow <= 1'b0;
      cycle <= (io_wr & (off == 8'h0C)) ? writedata : cycle + 32'd1;
    end
  end
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed bench for dmem_mmio with a queue-based reference model
module tb_dmem_mmio;
  localparam logic [31:0] OUT = 32'hFFFFFF00, TXD = 32'hFFFFFF04, STA = 32'hFFFFFF08, CYC = 32'hFFFFFF0C;
  logic clk = 0, reset, memwrite, tx_ready, tx_valid;
  logic [31:0] dataadr, writedata, readdata, gpio_out;
  logic [7:0] tx_data;
  int errors = 0, checks = 0;
  bit run = 0;
  logic [31:0] m_gpio, m_cyc, m_ram [int];
  logic [7:0] m_q [$];
  logic m_ovf;
  bit m_pop, m_full, m_io;

  dmem_mmio dut (.clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .readdata(readdata), .gpio_out(gpio_out), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic bit model_rd(input logic [31:0] a, output logic [31:0] v);
    int n = m_q.size();
    v = 32'h0;
    if (a[31:8] == 24'h0) begin
      if (!m_ram.exists(int'(a[7:2]))) return 0;
      v = m_ram[int'(a[7:2])];
    end else if (a[31:8] == 24'hFFFFFF) begin
      case (a[7:0])
        8'h00: v = m_gpio;
        8'h08: v = {16'h0, 8'(n), 5'h0, m_ovf, n == 0, n == 8};
        8'h0C: v = m_cyc;
        default: v = 32'h0;
      endcase
    end
    return 1;
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_gpio = 0; m_cyc = 0; m_ovf = 0; m_q.delete();
    end else begin
      m_io = dataadr[31:8] == 24'hFFFFFF;
      m_pop = m_q.size() != 0 && tx_ready;
      m_full = m_q.size() == 8;
      if (memwrite && dataadr[31:8] == 24'h0) m_ram[int'(dataadr[7:2])] = writedata;
      if (m_pop) void'(m_q.pop_front());
      if (memwrite && m_io && dataadr[7:0] == 8'h04) begin
        if (!m_full || m_pop) m_q.push_back(writedata[7:0]);
        else m_ovf = 1;
      end
      if (memwrite && m_io && dataadr[7:0] == 8'h08 && writedata[2]) m_ovf = 0;
      if (memwrite && m_io && dataadr[7:0] == 8'h00) m_gpio = writedata;
      m_cyc = (memwrite && m_io && dataadr[7:0] == 8'h0C) ? writedata : m_cyc + 32'd1;
    end
  end

  always @(negedge clk) if (run) begin
    logic [31:0] v;
    chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
    chk("tx_data", 32'(tx_data), m_q.size() != 0 ? 32'(m_q[0]) : 32'h0);
    chk("gpio_out", gpio_out, m_gpio);
    if (model_rd(dataadr, v)) chk("readdata", readdata, v);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1; dataadr = a; writedata = d;
    tick();
    memwrite = 0; dataadr = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    dataadr = a;
    @(negedge clk);
    chk(n, readdata, e);
    tick();
  endtask

  initial begin
    reset = 1; memwrite = 0; tx_ready = 0; dataadr = 0; writedata = 0;
    tick(); tick();
    run = 1;
    reset = 0;
    rd(STA, 32'h2, "status_after_reset");
    rd(OUT, 32'h0, "gpio_after_reset");
    wr(32'h24, 32'hDEADBEEF);
    rd(32'h24, 32'hDEADBEEF, "ram_rw");
    rd(32'h1000, 32'h0, "unmapped_rd");
    wr(32'h1000, 32'h1234);
    rd(32'h1000, 32'h0, "unmapped_wr_ignored");
    rd(32'hFFFFFF10, 32'h0, "io_other_rd");
    rd(TXD, 32'h0, "txdata_rd");
    tx_ready = 1; tick(); tick(); tx_ready = 0;
    rd(STA, 32'h2, "ready_while_empty");
    for (int i = 0; i < 8; i++) wr(TXD, 32'h11 + i);
    rd(STA, 32'h0801, "status_full");
    wr(TXD, 32'h99);
    rd(STA, 32'h0805, "status_overflow");
    tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("drain_data", 32'(tx_data), 32'h11 + i);
      tick();
    end
    tx_ready = 0;
    @(negedge clk);
    chk("drained_valid", 32'(tx_valid), 32'h0);
    chk("drained_data", 32'(tx_data), 32'h0);
    tick();
    wr(STA, 32'h4);
    rd(STA, 32'h2, "ovf_cleared");
    wr(OUT, 32'h5A);
    @(negedge clk);
    chk("gpio_5a", gpio_out, 32'h5A);
    tick();
    rd(OUT, 32'h5A, "outreg_rd");
    for (int i = 0; i < 8; i++) wr(TXD, 32'h21 + i);
    tx_ready = 1;
    wr(TXD, 32'hAA);
    tx_ready = 0;
    rd(STA, 32'h0801, "full_push_pop");
    tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("drain2_data", 32'(tx_data), i == 7 ? 32'hAA : 32'h22 + i);
      tick();
    end
    tx_ready = 0;
    wr(TXD, 32'h41);
    tx_ready = 1;
    wr(TXD, 32'h42);
    tx_ready = 0;
    @(negedge clk);
    chk("pushpop_data", 32'(tx_data), 32'h42);
    tick();
    rd(STA, 32'h0100, "pushpop_count");
    tx_ready = 1; tick(); tx_ready = 0;
    wr(CYC, 32'hFFFFFFFE);
    dataadr = CYC;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cycle_wrap", readdata, 32'(32'hFFFFFFFE + i));
      tick();
    end
    wr(TXD, 32'h31);
    wr(TXD, 32'h32);
    wr(OUT, 32'h77);
    wr(TXD, 32'h33);
    reset = 1;
    #2;
    chk("rst_gpio", gpio_out, 32'h0);
    chk("rst_valid", 32'(tx_valid), 32'h0);
    chk("rst_data", 32'(tx_data), 32'h0);
    tick();
    reset = 0;
    dataadr = CYC;
    @(negedge clk);
    chk("rst_cycle", readdata, 32'h0);
    tick();
    rd(STA, 32'h2, "rst_status");
    rd(32'h24, 32'hDEADBEEF, "ram_kept");
    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
